efp_result_packer: RTL and testbench
====================================

Name: efp_result_packer

Overview:
- Back end of the EFP adder datapath; the adder unpacks two 24-bit EFP words into fields, and this block goes the other way.
- Takes raw result fields: sign, biased exponent, and a possibly unnormalized significand with variable mantissa width.
- Normalizes iteratively, rounds to a requested output mantissa width, and packs one 24-bit EFP word.
- Word layout: [23]=sign, [22:19]=biased exponent, [18:0]=fraction right-aligned in the low out_m_bits bits, upper bits zero.
- Sits between Add1 and the VIO/result consumer; valid/ready on both sides.

Parameters:
- EXP_W, 4: packed exponent field width. Maximum finite exponent is 2^EXP_W-1.
- FRAC_W, 19: packed fraction field width.
- CYC_W, 8: width of the per-result latency counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: input fields valid.
- in_ready, output, 1: block can accept. High only in IDLE.
- in_sign, input, 1: result sign.
- in_exp, input, EXP_W+1: biased exponent, 0..31.
- in_sig, input, FRAC_W+1: significand. Value = in_sig / 2^in_m_bits. Hidden bit nominally at bit in_m_bits.
- in_m_bits, input, 5: input mantissa width. Values >18 are clamped to 18.
- out_m_bits, input, 5: output mantissa width. Values >19 are clamped to 19. Sampled on accept.
- out_valid, output, 1: packed word valid.
- out_ready, input, 1: consumer accepts.
- out_word, output, 24: packed EFP word.
- out_ovf, output, 1: result saturated.
- out_unf, output, 1: result flushed to zero.
- out_inexact, output, 1: rounding discarded nonzero bits.
- out_cycles, output, CYC_W: cycles from accept to out_valid.
- stat_ovf_cnt, output, 16: optional statistics counter (see Optional Feature).
- stat_unf_cnt, output, 16: optional statistics counter.
- stat_inx_cnt, output, 16: optional statistics counter.

Behaviour:
- Reset (async): state=IDLE, in_ready=1, out_valid=0, out_word=0, all flags=0, out_cycles=0, stat counters=0. Reset mid-operation discards the item in flight; no output is produced for it.
- IDLE: on in_valid&in_ready, capture sign, exp (internal 6-bit), sig, sticky=0, clamped M=in_m_bits, clamped OM=out_m_bits, cyc=0. Go to NORM.
- NORM, one action per cycle; cyc increments every NORM and ROUND cycle:
  - If sig>>(M+1) != 0: sticky |= sig[0], sig >>= 1, exp += 1.
  - Else if sig[M]==0 and sig!=0 and exp>0: sig <<= 1, exp -= 1.
  - Else go to ROUND.
- ROUND (single cycle, combinational within the cycle):
  - If OM>=M: frac = sig << (OM-M), exact.
  - Else drop d=M-OM bits using round-to-nearest-even: guard = MSB dropped, sticky = OR of the rest plus the captured sticky. inexact = guard|sticky.
  - If rounding carries to bit OM+1: shift right once, exp += 1.
  - Then classify:
    - sig==0: word={sign,0}, no flags.
    - exp==0: word={sign,0}, out_unf=1.
    - exp>15: word={sign,4'hF, OM ones}, out_ovf=1.
    - Otherwise: word={sign, exp[3:0], frac low OM bits, hidden bit removed}.
  - Register word, flags, out_cycles=cyc+1. Assert out_valid. Go to OUT.
- OUT: hold all outputs stable while out_valid & !out_ready. On out_ready, drop out_valid and return to IDLE; in_ready returns high the next cycle. No new accept is possible in the handshake cycle.
- Latency: out_valid rises 2+S cycles after the accept edge, where S is the shift count (S ≤ 20). out_cycles reports 2+S.
- Exponent arithmetic uses 6 bits internally and never wraps. Left shifts stop at exp 0, so denormals are not supported.

Optional Feature:
- Macro: EFP_PACK_STATS_EN.
- Defined: three 16-bit saturating counters increment on each output handshake whose out_ovf, out_unf, or out_inexact is set. They hold at 16'hFFFF and clear only on rst.
- Not defined: counter logic is absent; stat ports are tied to 0.

Test Plan:
- Normalized input: sign 0, exp 7, sig 0b1100, in_m_bits 3, out_m_bits 3 -> out_word 0x380004, no flags, out_cycles 2.
- Carry-out: exp 7, sig 0b11000, M 3, OM 3 -> one right shift, out_word 0x400004, out_cycles 3.
- RNE rounding, M 4, OM 2, exp 7:
  - sig 0b11011 -> 0x380003, inexact=1.
  - Tie sig 0b10010 -> 0x380000, inexact=1 (rounds to even).
- Overflow: exp 15, sig 0b11000, M 3, OM 3 -> 0x780007, out_ovf=1. Underflow: sign 1, exp 1, sig 0b0100, M 3 -> 0x800000, out_unf=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: out_word and flags stay stable, in_ready stays 0.
  - Assert rst during NORM: out_valid stays 0 and in_ready=1 immediately.
- With EFP_PACK_STATS_EN defined, 3 overflowing results then 1 exact result -> stat_ovf_cnt=3, stat_inx_cnt=0.

Source files
------------

// File: rtl/efp_result_packer_if.sv
// Valid/ready bundle between the EFP adder back end and its producer/consumer.
// slave is the packer's view; master is the view of whatever drives it.
interface efp_result_packer_if #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 19,
    parameter int CYC_W  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W:0]          in_exp;
    logic [FRAC_W:0]         in_sig;
    logic [4:0]              in_m_bits;
    logic [4:0]              out_m_bits;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_word;
    logic                    out_ovf;
    logic                    out_unf;
    logic                    out_inexact;
    logic [CYC_W-1:0]        out_cycles;

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_m_bits, out_m_bits, out_ready,
        output in_ready, out_valid, out_word, out_ovf, out_unf, out_inexact, out_cycles
    );

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_m_bits, out_m_bits, out_ready,
        input  in_ready, out_valid, out_word, out_ovf, out_unf, out_inexact, out_cycles
    );
endinterface

// File: rtl/efp_result_packer.sv
// Normalizes, RNE-rounds and packs raw EFP result fields into one 24-bit word.
// Optional saturating flag statistics are enabled with the EFP_PACK_STATS_EN macro.
module efp_result_packer #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 19,
    parameter int CYC_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    efp_result_packer_if.slave  bus,
    output logic [15:0]         stat_ovf_cnt,
    output logic [15:0]         stat_unf_cnt,
    output logic [15:0]         stat_inx_cnt
);
    localparam int SIG_W   = FRAC_W + 1;
    localparam int WORD_W  = 1 + EXP_W + FRAC_W;
    localparam int M_MAX   = FRAC_W - 1;
    localparam int OM_MAX  = FRAC_W;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             state;
    logic               sign_r;
    logic [5:0]         exp_r;
    logic [SIG_W-1:0]   sig_r;
    logic               sticky_r;
    logic [4:0]         m_r;
    logic [4:0]         om_r;
    logic [CYC_W-1:0]   cyc_r;

    logic [4:0] m_clamp, om_clamp;
    assign m_clamp  = (bus.in_m_bits  > 5'(M_MAX))  ? 5'(M_MAX)  : bus.in_m_bits;
    assign om_clamp = (bus.out_m_bits > 5'(OM_MAX)) ? 5'(OM_MAX) : bus.out_m_bits;

    logic need_rshift, can_lshift;
    assign need_rshift = (sig_r >> (m_r + 5'd1)) != '0;
    assign can_lshift  = !sig_r[m_r] && (sig_r != '0) && (exp_r != '0);

    logic [4:0]        d;
    logic [SIG_W-1:0]  kept, rest_mask, frac_full, frac_mask;
    logic              guard, stk, up, carry, inexact;
    logic [5:0]        exp_fin;
    logic [WORD_W-1:0] word_n;
    logic              ovf_n, unf_n, inx_n;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d         = m_r - om_r;
        kept      = '0;
        rest_mask = '0;
        guard     = 1'b0;
        stk       = 1'b0;
        up        = 1'b0;
        inexact   = 1'b0;
        exp_fin   = exp_r;
        word_n    = {sign_r, {(WORD_W-1){1'b0}}};
        ovf_n     = 1'b0;
        unf_n     = 1'b0;
        inx_n     = 1'b0;
        if (om_r >= m_r) begin
            frac_full = sig_r << (om_r - m_r);
        end else begin
            kept      = sig_r >> d;
            guard     = sig_r[d - 5'd1];
            rest_mask = (SIG_W'(1) << (d - 5'd1)) - SIG_W'(1);
            stk       = (|(sig_r & rest_mask)) | sticky_r;
            up        = guard & (stk | kept[0]);
            frac_full = kept + SIG_W'(up);
            inexact   = guard | stk;
        end
        // Round-up can carry past the hidden bit; renormalize once.
        carry = (frac_full >> ({1'b0, om_r} + 6'd1)) != '0;
        if (carry) begin
            frac_full = frac_full >> 1;
            exp_fin   = exp_r + 6'd1;
        end
        frac_mask = (SIG_W'(1) << om_r) - SIG_W'(1);
        if (sig_r == '0) begin
            word_n = {sign_r, {(WORD_W-1){1'b0}}};
        end else if (exp_fin == '0) begin
            unf_n = 1'b1;
            inx_n = inexact;
        end else if (exp_fin > 6'(EXP_MAX)) begin
            word_n = {sign_r, {EXP_W{1'b1}}, FRAC_W'(frac_mask)};
            ovf_n  = 1'b1;
            inx_n  = inexact;
        end else begin
            word_n = {sign_r, exp_fin[EXP_W-1:0], FRAC_W'(frac_full & frac_mask)};
            inx_n  = inexact;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_word    <= '0;
            bus.out_ovf     <= 1'b0;
            bus.out_unf     <= 1'b0;
            bus.out_inexact <= 1'b0;
            bus.out_cycles  <= '0;
            sign_r          <= 1'b0;
            exp_r           <= '0;
            sig_r           <= '0;
            sticky_r        <= 1'b0;
            m_r             <= '0;
            om_r            <= '0;
            cyc_r           <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    sign_r       <= bus.in_sign;
                    exp_r        <= 6'(bus.in_exp);
                    sig_r        <= bus.in_sig;
                    sticky_r     <= 1'b0;
                    m_r          <= m_clamp;
                    om_r         <= om_clamp;
                    cyc_r        <= '0;
                    bus.in_ready <= 1'b0;
                    state        <= NORM;
                end
                NORM: begin
                    cyc_r <= cyc_r + CYC_W'(1);
                    if (need_rshift) begin
                        sticky_r <= sticky_r | sig_r[0];
                        sig_r    <= sig_r >> 1;
                        exp_r    <= exp_r + 6'd1;
                    end else if (can_lshift) begin
                        sig_r <= sig_r << 1;
                        exp_r <= exp_r - 6'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    cyc_r           <= cyc_r + CYC_W'(1);
                    bus.out_word    <= word_n;
                    bus.out_ovf     <= ovf_n;
                    bus.out_unf     <= unf_n;
                    bus.out_inexact <= inx_n;
                    bus.out_cycles  <= cyc_r + CYC_W'(1);
                    bus.out_valid   <= 1'b1;
                    state           <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EFP_PACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ovf_cnt <= '0;
            stat_unf_cnt <= '0;
            stat_inx_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (bus.out_ovf && stat_ovf_cnt != 16'hFFFF)     stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
            if (bus.out_unf && stat_unf_cnt != 16'hFFFF)     stat_unf_cnt <= stat_unf_cnt + 16'd1;
            if (bus.out_inexact && stat_inx_cnt != 16'hFFFF) stat_inx_cnt <= stat_inx_cnt + 16'd1;
        end
    end
`else
    assign stat_ovf_cnt = '0;
    assign stat_unf_cnt = '0;
    assign stat_inx_cnt = '0;
`endif
endmodule

// File: tb/tb_efp_result_packer.sv
// Directed bench for efp_result_packer: hand-computed vectors, backpressure,
// reset during normalization and the optional flag statistics.
module tb_efp_result_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] stat_ovf_cnt, stat_unf_cnt, stat_inx_cnt;
    int          checks = 0;
    int          errors = 0;
    int          m_ovf = 0, m_unf = 0, m_inx = 0;

    efp_result_packer_if #(.EXP_W(4), .FRAC_W(19), .CYC_W(8)) bus ();

    efp_result_packer #(.EXP_W(4), .FRAC_W(19), .CYC_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stat_ovf_cnt (stat_ovf_cnt),
        .stat_unf_cnt (stat_unf_cnt),
        .stat_inx_cnt (stat_inx_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Send one item, wait for the result, check it, optionally stall, then hand it off.
    task automatic do_vec(input string tag, input logic sign, input logic [4:0] e,
                          input logic [19:0] sig, input logic [4:0] m, input logic [4:0] om,
                          input logic [23:0] x_word, input logic x_ovf, input logic x_unf,
                          input logic x_inx, input int x_cyc, input int hold);
        int lat;
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.in_sign    = sign;
        bus.in_exp     = e;
        bus.in_sig     = sig;
        bus.in_m_bits  = m;
        bus.out_m_bits = om;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(x_cyc));
        check({tag, "_word"},    32'(bus.out_word), 32'(x_word));
        check({tag, "_flags"},   {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact},
                                 {29'd0, x_ovf, x_unf, x_inx});
        check({tag, "_cycles"},  32'(bus.out_cycles), 32'(x_cyc));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {6'd0, bus.in_ready, bus.out_valid, bus.out_word},
                                  {6'd0, 1'b0, 1'b1, x_word});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, bus.out_valid, bus.in_ready}, {30'd0, 1'b0, 1'b1});
        if (x_ovf) m_ovf++;
        if (x_unf) m_unf++;
        if (x_inx) m_inx++;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_exp     = '0;
        bus.in_sig     = '0;
        bus.in_m_bits  = '0;
        bus.out_m_bits = '0;
        bus.out_ready  = 1'b0;
        #22 rst = 1'b0;
        #1;
        check("reset_ctrl",  {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
        check("reset_word",  32'(bus.out_word), 32'd0);
        check("reset_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
        check("reset_cyc",   32'(bus.out_cycles), 32'd0);
        check("reset_stats", {stat_ovf_cnt, stat_unf_cnt ^ stat_inx_cnt}, 32'd0);

        //     tag       sgn exp  sig        M   OM  word       ovf  unf  inx  cyc hold
        do_vec("norm",    0, 7,  20'b1100,  3,  3,  24'h380004, 0, 0, 0, 2, 0);
        do_vec("carry",   0, 7,  20'b11000, 3,  3,  24'h400004, 0, 0, 0, 3, 0);
        do_vec("rne_up",  0, 7,  20'b11011, 4,  2,  24'h380003, 0, 0, 1, 2, 5);
        do_vec("rne_tie", 0, 7,  20'b10010, 4,  2,  24'h380000, 0, 0, 1, 2, 0);
        do_vec("ovf",     0, 15, 20'b11000, 3,  3,  24'h780007, 1, 0, 0, 3, 0);
        do_vec("unf",     1, 1,  20'b0100,  3,  3,  24'h800000, 0, 1, 0, 3, 0);
        do_vec("lshift",  0, 7,  20'b0011,  3,  3,  24'h280004, 0, 0, 0, 4, 0);
        do_vec("zero",    1, 9,  20'd0,     3,  3,  24'h800000, 0, 0, 0, 2, 0);
        do_vec("clamp",   0, 5,  20'h40001, 31, 31, 24'h280002, 0, 0, 0, 2, 0);

        // Reset while still normalizing: the item must vanish.
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 5'd7;
        bus.in_sig    = 20'd1;
        bus.in_m_bits = 5'd18;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("norm_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
        #12 rst = 1'b0;
        m_ovf = 0; m_unf = 0; m_inx = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) break;
        end
        check("rst_no_out", 32'(bus.out_valid), 32'd0);

        do_vec("st_ovf0", 0, 15, 20'b11000, 3, 3, 24'h780007, 1, 0, 0, 3, 0);
        do_vec("st_ovf1", 1, 15, 20'b11000, 3, 3, 24'hF80007, 1, 0, 0, 3, 0);
        do_vec("st_ovf2", 0, 15, 20'b11000, 3, 3, 24'h780007, 1, 0, 0, 3, 0);
        do_vec("st_exact", 0, 7, 20'b1100,  3, 3, 24'h380004, 0, 0, 0, 2, 0);
`ifdef EFP_PACK_STATS_EN
        check("stat_ovf", 32'(stat_ovf_cnt), 32'(m_ovf));
        check("stat_unf", 32'(stat_unf_cnt), 32'(m_unf));
        check("stat_inx", 32'(stat_inx_cnt), 32'(m_inx));
`else
        check("stat_ovf", 32'(stat_ovf_cnt), 32'd0);
        check("stat_unf", 32'(stat_unf_cnt), 32'd0);
        check("stat_inx", 32'(stat_inx_cnt), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
